// File: rtl/crash_ctrl.sv
// crash_ctrl: per-pixel crash strobes, frame-aligned bomb strobe, lives/bomb
// bookkeeping, post-hit invincibility window and the IDLE/RUN/OVER game FSM.
module crash_ctrl #(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned LIVES_BIT_LEN  = 2,
    parameter int unsigned BOMB_INIT      = 1,
    parameter int unsigned BOMB_MAX       = 3,
    parameter int unsigned BOMB_BIT_LEN   = 2,
    parameter int unsigned INVINC_FRAMES  = 120,
    parameter int unsigned INVINC_BIT_LEN = 7
) (
    input  logic                      clk_vga,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      bomb_key_i,
    input  logic                      bomb_add_i,
    input  logic                      v_sync_i,
    input  logic                      enemy_alpha_i,
    input  logic                      bullet_alpha_i,
    input  logic                      me_alpha_i,
    output logic                      crash_enemy_bullet_o,
    output logic                      crash_me_enemy_o,
    output logic                      bomb_o,
    output logic                      en_o,
    output logic [LIVES_BIT_LEN-1:0]  lives_o,
    output logic [BOMB_BIT_LEN-1:0]   bombs_o,
    output logic                      invincible_o,
    output logic                      game_over_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StOver = 2'd2;

    localparam logic [LIVES_BIT_LEN-1:0]  LivesInit = LIVES_BIT_LEN'(LIVES_INIT);
    localparam logic [LIVES_BIT_LEN-1:0]  LivesOne  = LIVES_BIT_LEN'(1);
    localparam logic [BOMB_BIT_LEN-1:0]   BombInit  = BOMB_BIT_LEN'(BOMB_INIT);
    localparam logic [BOMB_BIT_LEN-1:0]   BombMax   = BOMB_BIT_LEN'(BOMB_MAX);
    localparam logic [INVINC_BIT_LEN-1:0] InvLoad   = INVINC_BIT_LEN'(INVINC_FRAMES);
    localparam logic [INVINC_BIT_LEN-1:0] InvOne    = INVINC_BIT_LEN'(1);

    logic [1:0]                r_state, w_state_nxt;
    logic [LIVES_BIT_LEN-1:0]  r_lives, w_lives_nxt;
    logic [BOMB_BIT_LEN-1:0]   r_bombs, w_bombs_nxt;
    logic                      r_inv, w_inv_nxt;
    logic [INVINC_BIT_LEN-1:0] r_inv_cnt, w_inv_cnt_nxt;
    logic                      r_pend, w_pend_nxt;

    logic r_vs_q, r_fs, r_start_q, r_bomb_q;

    logic w_run, w_start_rise, w_bomb_rise, w_bomb_accept, w_hit;

    assign w_run         = (r_state == StRun);
    assign w_start_rise  = start_i & ~r_start_q;
    assign w_bomb_rise   = bomb_key_i & ~r_bomb_q;
    assign w_bomb_accept = w_run & w_bomb_rise & (r_bombs != '0) & ~r_pend;

    // Crash strobes stay combinational: enemy blocks latch their index this very cycle.
    assign crash_enemy_bullet_o = enemy_alpha_i & bullet_alpha_i & w_run;
    assign crash_me_enemy_o     = enemy_alpha_i & me_alpha_i & w_run & ~r_inv;
    assign w_hit                = crash_me_enemy_o;

    assign bomb_o       = r_fs & r_pend & w_run;
    assign en_o         = w_run;
    assign game_over_o  = (r_state == StOver);
    assign lives_o      = r_lives;
    assign bombs_o      = r_bombs;
    assign invincible_o = r_inv;

    // Edge-detect history and the registered frame-start pulse.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_q    <= 1'b0;
            r_fs      <= 1'b0;
            r_start_q <= 1'b0;
            r_bomb_q  <= 1'b0;
        end else begin
            r_vs_q    <= v_sync_i;
            r_fs      <= v_sync_i & ~r_vs_q;
            r_start_q <= start_i;
            r_bomb_q  <= bomb_key_i;
        end
    end

    // Next-state logic for the FSM, lives, bombs, invincibility and pending bomb.
    always_comb begin
        w_state_nxt   = r_state;
        w_lives_nxt   = r_lives;
        w_bombs_nxt   = r_bombs;
        w_inv_nxt     = r_inv;
        w_inv_cnt_nxt = r_inv_cnt;
        w_pend_nxt    = r_pend;
        case (r_state)
            StIdle, StOver: begin
                if (w_start_rise) begin
                    w_state_nxt   = StRun;
                    w_lives_nxt   = LivesInit;
                    w_bombs_nxt   = BombInit;
                    w_inv_nxt     = 1'b0;
                    w_inv_cnt_nxt = '0;
                    w_pend_nxt    = 1'b0;
                end
            end
            StRun: begin
                if (r_fs && (r_inv_cnt != '0)) begin
                    w_inv_cnt_nxt = r_inv_cnt - InvOne;
                    if (r_inv_cnt == InvOne) begin
                        w_inv_nxt = 1'b0;
                    end
                end
                // Accept needs pend=0 and fire needs pend=1, so these never collide.
                if (bomb_o) begin
                    w_pend_nxt = 1'b0;
                end
                if (w_bomb_accept) begin
                    w_pend_nxt = 1'b1;
                    // A pickup in the same cycle replaces the bomb just used.
                    if (!bomb_add_i) begin
                        w_bombs_nxt = r_bombs - BOMB_BIT_LEN'(1);
                    end
                end else if (bomb_add_i && (r_bombs != BombMax)) begin
                    w_bombs_nxt = r_bombs + BOMB_BIT_LEN'(1);
                end
                // A hit implies not invincible, so the countdown above was idle.
                if (w_hit) begin
                    if (r_lives == LivesOne) begin
                        w_state_nxt   = StOver;
                        w_lives_nxt   = '0;
                        w_inv_nxt     = 1'b0;
                        w_inv_cnt_nxt = '0;
                        w_pend_nxt    = 1'b0;
                    end else begin
                        w_lives_nxt   = r_lives - LivesOne;
                        w_inv_nxt     = 1'b1;
                        w_inv_cnt_nxt = InvLoad;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Game state registers.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_lives   <= '0;
            r_bombs   <= '0;
            r_inv     <= 1'b0;
            r_inv_cnt <= '0;
            r_pend    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lives   <= w_lives_nxt;
            r_bombs   <= w_bombs_nxt;
            r_inv     <= w_inv_nxt;
            r_inv_cnt <= w_inv_cnt_nxt;
            r_pend    <= w_pend_nxt;
        end
    end

endmodule

// File: tb/tb_crash_ctrl.sv
// Directed testbench for crash_ctrl: reset, start, hit/invincibility, game over,
// bomb use, bomb pickup and asynchronous mid-game reset.
module tb_crash_ctrl;

    logic       clk_vga = 1'b0;
    logic       rst_n;
    logic       start_i, bomb_key_i, bomb_add_i, v_sync_i;
    logic       enemy_alpha_i, bullet_alpha_i, me_alpha_i;
    logic       crash_enemy_bullet_o, crash_me_enemy_o, bomb_o, en_o;
    logic [1:0] lives_o, bombs_o;
    logic       invincible_o, game_over_o;

    int errors = 0;
    int checks = 0;

    crash_ctrl dut (
        .clk_vga              (clk_vga),
        .rst_n                (rst_n),
        .start_i              (start_i),
        .bomb_key_i           (bomb_key_i),
        .bomb_add_i           (bomb_add_i),
        .v_sync_i             (v_sync_i),
        .enemy_alpha_i        (enemy_alpha_i),
        .bullet_alpha_i       (bullet_alpha_i),
        .me_alpha_i           (me_alpha_i),
        .crash_enemy_bullet_o (crash_enemy_bullet_o),
        .crash_me_enemy_o     (crash_me_enemy_o),
        .bomb_o               (bomb_o),
        .en_o                 (en_o),
        .lives_o              (lives_o),
        .bombs_o              (bombs_o),
        .invincible_o         (invincible_o),
        .game_over_o          (game_over_o)
    );

    always #5 clk_vga = ~clk_vga;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    // One v_sync pulse; returns with the fs cycle already consumed.
    task automatic frame();
        v_sync_i = 1'b1;
        tick();
        v_sync_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 0; bomb_key_i = 0; bomb_add_i = 0; v_sync_i = 0;
        enemy_alpha_i = 1; bullet_alpha_i = 1; me_alpha_i = 1;
        #23;
        checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", en_o); end
        checks++; if (lives_o !== 2'd0) begin errors++; $display("FAIL reset_lives got=%0d exp=0", lives_o); end
        checks++; if (bombs_o !== 2'd0) begin errors++; $display("FAIL reset_bombs got=%0d exp=0", bombs_o); end
        checks++; if ({invincible_o, game_over_o, bomb_o} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {invincible_o, game_over_o, bomb_o}); end
        checks++; if ({crash_enemy_bullet_o, crash_me_enemy_o} !== 2'b00) begin
            errors++; $display("FAIL reset_crash got=%b exp=00", {crash_enemy_bullet_o, crash_me_enemy_o}); end
        enemy_alpha_i = 0; bullet_alpha_i = 0; me_alpha_i = 0;
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL idle_hold_en got=%b exp=0", en_o); end
    endtask

    task automatic test_start();
        start_i = 1'b1;
        tick();
        checks++; if (en_o !== 1'b1) begin errors++; $display("FAIL start_en got=%b exp=1", en_o); end
        checks++; if (lives_o !== 2'd3) begin errors++; $display("FAIL start_lives got=%0d exp=3", lives_o); end
        checks++; if (bombs_o !== 2'd1) begin errors++; $display("FAIL start_bombs got=%0d exp=1", bombs_o); end
        checks++; if (game_over_o !== 1'b0) begin errors++; $display("FAIL start_over got=%b exp=0", game_over_o); end
        start_i = 1'b0;
        tick();
        // Enemy/bullet overlap in RUN fires combinationally.
        enemy_alpha_i = 1; bullet_alpha_i = 1;
        #1;
        checks++; if (crash_enemy_bullet_o !== 1'b1) begin
            errors++; $display("FAIL run_crash_eb got=%b exp=1", crash_enemy_bullet_o); end
        checks++; if (crash_me_enemy_o !== 1'b0) begin
            errors++; $display("FAIL run_crash_me_noplane got=%b exp=0", crash_me_enemy_o); end
        enemy_alpha_i = 0; bullet_alpha_i = 0;
        tick();
        checks++; if (lives_o !== 2'd3) begin errors++; $display("FAIL eb_no_life_loss got=%0d exp=3", lives_o); end
    endtask

    task automatic test_hit_invinc();
        int hits;
        hits = 0;
        enemy_alpha_i = 1; me_alpha_i = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (crash_me_enemy_o !== (i == 0)) begin
                errors++; $display("FAIL hit_strobe cyc=%0d got=%b exp=%b", i, crash_me_enemy_o, (i == 0)); end
            if (crash_me_enemy_o === 1'b1) hits++;
            tick();
        end
        enemy_alpha_i = 0; me_alpha_i = 0;
        checks++; if (hits != 1) begin errors++; $display("FAIL hit_count got=%0d exp=1", hits); end
        checks++; if (lives_o !== 2'd2) begin errors++; $display("FAIL hit_lives got=%0d exp=2", lives_o); end
        checks++; if (invincible_o !== 1'b1) begin errors++; $display("FAIL hit_inv got=%b exp=1", invincible_o); end
        for (int f = 0; f < 119; f++) frame();
        checks++; if (invincible_o !== 1'b1) begin errors++; $display("FAIL inv_119 got=%b exp=1", invincible_o); end
        frame();
        checks++; if (invincible_o !== 1'b0) begin errors++; $display("FAIL inv_120 got=%b exp=0", invincible_o); end
    endtask

    task automatic test_game_over();
        // Second hit: 2 -> 1, then wait out invincibility.
        enemy_alpha_i = 1; me_alpha_i = 1;
        tick();
        enemy_alpha_i = 0; me_alpha_i = 0;
        checks++; if (lives_o !== 2'd1) begin errors++; $display("FAIL hit2_lives got=%0d exp=1", lives_o); end
        for (int f = 0; f < 120; f++) frame();
        enemy_alpha_i = 1; me_alpha_i = 1;
        tick();
        enemy_alpha_i = 0; me_alpha_i = 0;
        checks++; if (lives_o !== 2'd0) begin errors++; $display("FAIL over_lives got=%0d exp=0", lives_o); end
        checks++; if (game_over_o !== 1'b1) begin errors++; $display("FAIL over_flag got=%b exp=1", game_over_o); end
        checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL over_en got=%b exp=0", en_o); end
        checks++; if (invincible_o !== 1'b0) begin errors++; $display("FAIL over_inv got=%b exp=0", invincible_o); end
        enemy_alpha_i = 1; bullet_alpha_i = 1; me_alpha_i = 1;
        #1;
        checks++; if ({crash_enemy_bullet_o, crash_me_enemy_o} !== 2'b00) begin
            errors++; $display("FAIL over_crash got=%b exp=00", {crash_enemy_bullet_o, crash_me_enemy_o}); end
        enemy_alpha_i = 0; bullet_alpha_i = 0; me_alpha_i = 0;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (en_o !== 1'b1) begin errors++; $display("FAIL restart_en got=%b exp=1", en_o); end
        checks++; if (lives_o !== 2'd3) begin errors++; $display("FAIL restart_lives got=%0d exp=3", lives_o); end
        checks++; if (game_over_o !== 1'b0) begin errors++; $display("FAIL restart_over got=%b exp=0", game_over_o); end
        tick();
    endtask

    task automatic test_bomb_use();
        int pulses;
        checks++; if (bombs_o !== 2'd1) begin errors++; $display("FAIL bomb_pre got=%0d exp=1", bombs_o); end
        bomb_key_i = 1; tick();
        checks++; if (bombs_o !== 2'd0) begin errors++; $display("FAIL bomb_press1 got=%0d exp=0", bombs_o); end
        bomb_key_i = 0; tick();
        bomb_key_i = 1; tick();
        checks++; if (bombs_o !== 2'd0) begin errors++; $display("FAIL bomb_press2 got=%0d exp=0", bombs_o); end
        bomb_key_i = 0; tick();
        checks++; if (bomb_o !== 1'b0) begin errors++; $display("FAIL bomb_early got=%b exp=0", bomb_o); end
        v_sync_i = 1; #1;
        checks++; if (bomb_o !== 1'b0) begin errors++; $display("FAIL bomb_at_vs got=%b exp=0", bomb_o); end
        tick();
        checks++; if (bomb_o !== 1'b1) begin errors++; $display("FAIL bomb_fs got=%b exp=1", bomb_o); end
        v_sync_i = 0; tick();
        checks++; if (bomb_o !== 1'b0) begin errors++; $display("FAIL bomb_after got=%b exp=0", bomb_o); end
        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            v_sync_i = 1; tick(); if (bomb_o === 1'b1) pulses++;
            v_sync_i = 0; tick(); if (bomb_o === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL bomb_single got=%0d exp=0 extra", pulses); end
    endtask

    task automatic test_bomb_pickup();
        for (int i = 0; i < 4; i++) begin
            bomb_add_i = 1; tick(); bomb_add_i = 0; tick();
        end
        checks++; if (bombs_o !== 2'd3) begin errors++; $display("FAIL pickup_sat got=%0d exp=3", bombs_o); end
        bomb_key_i = 1; tick(); bomb_key_i = 0; tick();
        checks++; if (bombs_o !== 2'd2) begin errors++; $display("FAIL pickup_use got=%0d exp=2", bombs_o); end
        frame();
        bomb_key_i = 1; bomb_add_i = 1; tick();
        bomb_key_i = 0; bomb_add_i = 0;
        checks++; if (bombs_o !== 2'd2) begin errors++; $display("FAIL pickup_same got=%0d exp=2", bombs_o); end
        tick();
        v_sync_i = 1; tick();
        checks++; if (bomb_o !== 1'b1) begin errors++; $display("FAIL pickup_fire got=%b exp=1", bomb_o); end
        v_sync_i = 0; tick();
        checks++; if (bombs_o !== 2'd2) begin errors++; $display("FAIL pickup_after got=%0d exp=2", bombs_o); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        bomb_key_i = 1; tick(); bomb_key_i = 0;
        enemy_alpha_i = 1; me_alpha_i = 1; tick();
        enemy_alpha_i = 0; me_alpha_i = 0;
        checks++; if ({invincible_o, bombs_o, lives_o} !== {1'b1, 2'd1, 2'd2}) begin
            errors++; $display("FAIL mid_setup got=%b exp=10110", {invincible_o, bombs_o, lives_o}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({en_o, lives_o, bombs_o, invincible_o, game_over_o, bomb_o} !== 8'd0) begin
            errors++; $display("FAIL mid_async got=%b exp=00000000",
                {en_o, lives_o, bombs_o, invincible_o, game_over_o, bomb_o}); end
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            v_sync_i = 1; tick(); if (bomb_o === 1'b1) pulses++;
            v_sync_i = 0; tick(); if (bomb_o === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mid_no_bomb got=%0d exp=0", pulses); end
        checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b exp=0", en_o); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit_invinc();
        test_game_over();
        test_bomb_use();
        test_bomb_pickup();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
